// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Single-outstanding instruction fetch stage. Issues one word
//                request at a time, holds the returned word for decode, and
//                handles control-flow redirects, including a redirect that
//                arrives while a request is still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [31:0] C_NOP       = 32'h0000_0013;
    localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] C_RST_PC    = RESET_ADDR & C_WORD_MASK;

    state_t      state_q, state_d;
    logic        active_q, active_d;     // low only until the first edge after reset
    logic        drop_q, drop_d;         // in-flight request belongs to a stale path
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;   // redirect target waiting for the stale ack
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;

    logic [31:0] w_redirect_pc;
    logic        w_req;

    assign w_redirect_pc = i_redirect_pc & C_WORD_MASK;
    assign w_req         = (state_q == S_REQ) && active_q;

    assign o_imem_req  = w_req;
    assign o_imem_addr = fetch_pc_q;
    assign o_inst      = inst_q;
    assign o_pc        = pc_q;
    assign o_valid     = (state_q == S_HOLD);

    // Next-state logic: request / hold sequencing, redirect and drop handling
    always_comb begin
        state_d    = state_q;
        active_d   = 1'b1;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        case (state_q)
            S_REQ: begin
                // The ack is meaningful only while a request is being driven
                if (active_q) begin
                    if (drop_q) begin
                        if (i_imem_ack) begin
                            // Stale data is thrown away; a same-cycle redirect is the newest target
                            drop_d     = 1'b0;
                            fetch_pc_d = i_redirect ? w_redirect_pc : pend_pc_q;
                        end else if (i_redirect) begin
                            pend_pc_d = w_redirect_pc;
                        end
                    end else if (i_redirect) begin
                        if (i_imem_ack) begin
                            fetch_pc_d = w_redirect_pc;
                        end else begin
                            // Keep the bus request stable; retire it silently when it completes
                            drop_d    = 1'b1;
                            pend_pc_d = w_redirect_pc;
                        end
                    end else if (i_imem_ack) begin
                        state_d = S_HOLD;
                        inst_d  = i_imem_rdata;
                        pc_d    = fetch_pc_q;
                    end
                end
            end
            S_HOLD: begin
                if (i_redirect) begin
                    fetch_pc_d = w_redirect_pc;
                    state_d    = S_REQ;
                end else if (i_ready) begin
                    fetch_pc_d = pc_q + 32'd4;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State registers with asynchronous reset that abandons any pending redirect
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_REQ;
            active_q   <= 1'b0;
            drop_q     <= 1'b0;
            fetch_pc_q <= C_RST_PC;
            pend_pc_q  <= C_RST_PC;
            inst_q     <= C_NOP;
            pc_q       <= C_RST_PC;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_ADDR SHALL default to 32'h0000_0000 and SHALL be the first fetch address after reset.
REQ-002 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 o_imem_req  output  1  SHALL indicate a fetch request to instruction memory.
REQ-005 o_imem_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-006 i_imem_ack  input  1  SHALL indicate that i_imem_rdata is valid this cycle; it SHALL be sampled only while o_imem_req=1.
REQ-007 i_imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-008 o_inst  output  32  SHALL carry the instruction word presented to the decode/immediate stage.
REQ-009 o_pc  output  32  SHALL carry the address of o_inst.
REQ-010 o_valid  output  1  SHALL indicate that o_inst/o_pc hold a live instruction.
REQ-011 i_ready  input  1  SHALL indicate that the decode stage accepts o_inst this cycle.
REQ-012 i_redirect  input  1  SHALL request a control-flow change (taken branch, JAL, JALR).
REQ-013 i_redirect_pc  input  32  SHALL carry the redirect target.

Function
REQ-014 The block SHALL implement states REQ (request outstanding) and HOLD (instruction held for decode), plus an internal drop flag.
REQ-015 In REQ, o_imem_req SHALL be 1 and o_imem_addr SHALL equal the fetch PC; both SHALL stay stable until the cycle i_imem_ack=1.
REQ-016 In REQ with ack=1 and drop=0: the next state SHALL be HOLD, o_inst SHALL capture i_imem_rdata, o_pc SHALL capture the fetch PC, and o_valid SHALL become 1 the next cycle.
REQ-017 In HOLD, o_imem_req SHALL be 0, and o_inst/o_pc/o_valid SHALL hold until handshake or redirect.
REQ-018 A handshake SHALL occur when o_valid=1 and i_ready=1; it SHALL set fetch PC = o_pc + 4 (modulo 2^32), clear o_valid, and enter REQ.
REQ-019 Minimum latency SHALL be request-to-valid 1 cycle (ack in the first REQ cycle), giving a peak throughput of one instruction per 2 cycles.
REQ-020 Redirect in HOLD SHALL discard the held instruction (no handshake counted even if i_ready=1), clear o_valid the next cycle, set fetch PC = i_redirect_pc, and enter REQ.
REQ-021 Redirect in REQ with ack=1 in the same cycle SHALL discard i_imem_rdata, set fetch PC = i_redirect_pc, and remain in REQ with a new request the next cycle.
REQ-022 Redirect in REQ with ack=0 SHALL keep the current request stable, set drop=1, and latch i_redirect_pc as the pending PC.
REQ-023 While drop=1, the next ack SHALL discard its data, clear drop, load the pending PC, and stay in REQ.
REQ-024 A further redirect while drop=1 SHALL overwrite the pending PC; the last redirect SHALL win.
REQ-025 i_redirect_pc[1:0] SHALL be forced to 2'b00; o_imem_addr[1:0] and o_pc[1:0] SHALL always be 0.
REQ-026 PC increment SHALL wrap, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 o_valid SHALL never be 1 for discarded data.

Reset
REQ-028 While i_rst=1, outputs SHALL be: o_valid=0, o_imem_req=0, o_inst=32'h0000_0013 (NOP), o_pc=RESET_ADDR, o_imem_addr=RESET_ADDR; state SHALL be REQ-pending with drop=0.
REQ-029 On the first clock edge after i_rst deasserts, o_imem_req SHALL be 1 with address RESET_ADDR.
REQ-030 Reset asserted mid-request or in HOLD SHALL abandon all state immediately, with no pending redirect retained.

Verification
REQ-031 Reset release, ack immediate, ready=1 always -> fetch addresses 0x0, 0x4, 0x8 with o_valid pulsing every 2nd cycle and o_pc matching.
REQ-032 Ack delayed 3 cycles -> o_imem_addr and o_imem_req held stable for 3 cycles; o_valid=1 the cycle after ack.
REQ-033 HOLD with i_ready=0 for 4 cycles, then 1 -> o_inst/o_pc unchanged throughout; next address = o_pc + 4.
REQ-034 Redirect to 0x103 in REQ with ack=0, ack arrives 2 cycles later -> that data is dropped, next request is 0x100, and o_valid stays 0 until 0x100 returns.
REQ-035 Redirect and i_ready=1 together in HOLD -> next request is the redirect PC, not o_pc + 4.
REQ-036 Fetch PC 32'hFFFF_FFFC handshaked -> next o_imem_addr = 0x0; i_rst pulse mid-request -> o_imem_req=0 immediately, then refetch RESET_ADDR.
